decode_stage: RTL

Instruction decode stage feeding the ALU. It takes a 32-bit RISC-V instruction from fetch and reads rs1/rs2 from an internal 32-entry register file with writeback bypass. It selects register or immediate operands and produces registered `ALUop1`/`ALUop2`/`ALUctrl` plus the writeback and branch controls for the downstream execute stage. Valid/ready handshakes on both sides; single output register.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/regfile.sv | 41 ++++
 rtl/decode_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants for the decode stage and its register file.
package riscv_pkg;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_B = 7'b1100011;

   typedef enum logic {
      ALU_ADD = 1'b0,
      ALU_EQ  = 1'b1
   } alu_ctrl_e;

endpackage

// File: rtl/regfile.sv
// 2-read/1-write register file with hard-wired x0 and same-cycle writeback bypass.
module regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr1,
   input  logic [ADDR_WIDTH-1:0] raddr2,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [DATA_WIDTH-1:0] rdata2
);
   localparam int NREGS = 1 << ADDR_WIDTH;

   logic [NREGS-1:0][DATA_WIDTH-1:0] mem_q, mem_d;

   always_comb begin
      mem_d = mem_q;
      if (we && (waddr != '0))
         mem_d[waddr] = wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mem_q <= '0;
      else        mem_q <= mem_d;
   end

   // Bypass lets a decode see a writeback landing on the same edge.
   always_comb begin
      rdata1 = mem_q[raddr1];
      rdata2 = mem_q[raddr2];
      if (we && (waddr == raddr1)) rdata1 = wdata;
      if (we && (waddr == raddr2)) rdata2 = wdata;
      if (raddr1 == '0) rdata1 = '0;
      if (raddr2 == '0) rdata2 = '0;
   end

endmodule

// File: rtl/decode_stage.sv
// RV32 decode for ADD/ADDI/BEQ/BNE: operand read, immediate select and a
// single valid/ready output register toward execute.
module decode_stage
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           instr,
   output logic                  out_valid,
   input  logic                  out_ready,
   input  logic                  flush,
   input  logic                  wb_en,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic [DATA_WIDTH-1:0] ALUop1,
   output logic [DATA_WIDTH-1:0] ALUop2,
   output logic                  ALUctrl,
   output logic [ADDR_WIDTH-1:0] rd,
   output logic                  reg_write,
   output logic                  branch,
   output logic                  branch_ne,
   output logic [DATA_WIDTH-1:0] branch_off,
   output logic                  illegal
);
   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [ADDR_WIDTH-1:0] rs1_addr, rs2_addr, rd_addr;
   logic [DATA_WIDTH-1:0] rs1_val, rs2_val, imm_i, imm_b;
   logic                  accept;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign funct7   = instr[31:25];
   assign rs1_addr = instr[15 +: ADDR_WIDTH];
   assign rs2_addr = instr[20 +: ADDR_WIDTH];
   assign rd_addr  = instr[7 +: ADDR_WIDTH];
   assign imm_i    = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
   assign imm_b    = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};

   regfile #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (wb_en),
      .waddr  (wb_addr),
      .wdata  (wb_data),
      .raddr1 (rs1_addr),
      .raddr2 (rs2_addr),
      .rdata1 (rs1_val),
      .rdata2 (rs2_val)
   );

   logic [DATA_WIDTH-1:0] dec_op2;
   alu_ctrl_e             dec_ctrl;
   logic                  dec_rw, dec_br, dec_bne, dec_ill;

   always_comb begin
      dec_op2  = rs2_val;
      dec_ctrl = ALU_ADD;
      dec_rw   = 1'b0;
      dec_br   = 1'b0;
      dec_bne  = 1'b0;
      dec_ill  = 1'b0;
      case (opcode)
         OP_R: begin
            if (funct3 == 3'b000 && funct7 == 7'b0000000) dec_rw  = 1'b1;
            else                                          dec_ill = 1'b1;
         end
         OP_I: begin
            if (funct3 == 3'b000) begin
               dec_op2 = imm_i;
               dec_rw  = 1'b1;
            end else begin
               dec_ill = 1'b1;
            end
         end
         OP_B: begin
            if (funct3[2:1] == 2'b00) begin
               dec_ctrl = ALU_EQ;
               dec_br   = 1'b1;
               dec_bne  = funct3[0];
            end else begin
               dec_ill = 1'b1;
            end
         end
         default: dec_ill = 1'b1;
      endcase
   end

   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, boff_q, boff_d;
   alu_ctrl_e             ctrl_q, ctrl_d;
   logic [ADDR_WIDTH-1:0] rd_q, rd_d;
   logic                  rw_q, rw_d, br_q, br_d, bne_q, bne_d, ill_q, ill_d;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   always_comb begin
      out_valid_d = out_valid_q;
      op1_d  = op1_q;
      op2_d  = op2_q;
      boff_d = boff_q;
      ctrl_d = ctrl_q;
      rd_d   = rd_q;
      rw_d   = rw_q;
      br_d   = br_q;
      bne_d  = bne_q;
      ill_d  = ill_q;
      if (flush)          out_valid_d = 1'b0;
      else if (accept)    out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;
      // Payload only moves on accept, so a stalled bundle ignores later writebacks.
      if (accept) begin
         op1_d  = rs1_val;
         op2_d  = dec_op2;
         boff_d = imm_b;
         ctrl_d = dec_ctrl;
         rd_d   = rd_addr;
         rw_d   = dec_rw;
         br_d   = dec_br;
         bne_d  = dec_bne;
         ill_d  = dec_ill;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         op1_q  <= '0;
         op2_q  <= '0;
         boff_q <= '0;
         ctrl_q <= ALU_ADD;
         rd_q   <= '0;
         rw_q   <= 1'b0;
         br_q   <= 1'b0;
         bne_q  <= 1'b0;
         ill_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         op1_q  <= op1_d;
         op2_q  <= op2_d;
         boff_q <= boff_d;
         ctrl_q <= ctrl_d;
         rd_q   <= rd_d;
         rw_q   <= rw_d;
         br_q   <= br_d;
         bne_q  <= bne_d;
         ill_q  <= ill_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign ALUop1     = op1_q;
   assign ALUop2     = op2_q;
   assign ALUctrl    = ctrl_q;
   assign rd         = rd_q;
   assign reg_write  = rw_q;
   assign branch     = br_q;
   assign branch_ne  = bne_q;
   assign branch_off = boff_q;
   assign illegal    = ill_q;

endmodule
